// File: rtl/boot_loader_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// boot_loader_ctrl_pkg
// Shared definitions for the framed boot loader:
//   - state_t : loader FSM states
//   - err_t   : error codes reported on err_o
//   - default frame start and end marks
//   - is_frame_state() : true while a frame is being received
// ----------------------------------------------------------------------------
package boot_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_END,
        ST_RUN,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_END     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] DEFAULT_START_MARK = 8'hA5;
    localparam logic [7:0] DEFAULT_END_MARK   = 8'h5A;

    // States in which a frame is in progress: busy, and the idle timer runs.
    function automatic logic is_frame_state(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_END);
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_byte_packer.sv
// ----------------------------------------------------------------------------
// boot_loader_ctrl_byte_packer
// Packs accepted bytes little-endian into 32-bit words (first byte at [7:0]).
// Ports:
//   sys_clk, sys_reset_n : clock, synchronous active-low reset
//   data                 : byte to pack
//   accept               : data is taken this cycle
//   clear                : restart at lane 0 (takes priority over accept)
//   word                 : last completed word (held until the next one)
//   word_valid           : one-cycle pulse, the cycle after lane 3 is taken
//   last_lane            : the next accepted byte completes a word
// ----------------------------------------------------------------------------
module boot_loader_ctrl_byte_packer (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic [7:0]  data,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_lane
);

    logic [1:0]  lane_q;
    logic [23:0] low_q;    // lanes 0..2 of the word being assembled

    assign last_lane = (lane_q == 2'd3);

    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            lane_q     <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= accept && !clear && last_lane;
            if (clear) begin
                lane_q <= 2'd0;
            end else if (accept) begin
                lane_q <= lane_q + 2'd1;
                if (last_lane) begin
                    word <= {data, low_q};
                end
            end
        end
    end

    // NOTE: pure datapath register with no reset: lanes 0..2 are always
    // rewritten before a word is completed, so their power-up value never leaks.
    always_ff @(posedge sys_clk) begin
        if (accept && !clear) begin
            low_q <= {data, low_q[23:8]};
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// ----------------------------------------------------------------------------
// boot_loader_ctrl
// Framed byte-stream loader: START_MARK, 16-bit word count (LSB first),
// payload words (4 bytes each, little-endian), END_MARK. Each word is written
// to instruction memory with a single-cycle strobe; the CPU run enable is
// raised only after a valid end mark.
// Ports:
//   sys_clk, sys_reset_n : clock, synchronous active-low reset
//   byte_i, byte_valid_i : incoming byte stream
//   byte_ready_o         : loader takes a byte this cycle (combinational)
//   clear_i              : RUN/ERROR -> IDLE
//   imem_we_o, imem_addr_o, imem_wdata_o : instruction memory write port
//   cpu_start_o          : pipeline run enable
//   busy_o               : frame in progress
//   err_o                : 0 none, 1 length, 2 end mark, 3 timeout
//   word_cnt_o           : words written in the current or last frame
// ----------------------------------------------------------------------------
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int         IMEM_DEPTH = 256,
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] START_MARK = DEFAULT_START_MARK,
    parameter logic [7:0] END_MARK   = DEFAULT_END_MARK,
    parameter int         TIMEOUT    = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              clear_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic [1:0]        err_o,
    output logic [15:0]       word_cnt_o
);

    localparam int          IDLE_W  = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN = 16'(IMEM_DEPTH);

    state_t            state_q, state_d;
    err_t              err_q, err_d;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt_q;    // also the write index of the next word
    logic [IDLE_W-1:0] idle_q;

    logic        accepted;
    logic        in_frame;
    logic        timeout_hit;
    logic        start_seen;
    logic [15:0] len_rx;
    logic        pk_accept;
    logic        pk_clear;
    logic        pk_last_lane;
    logic        word_done;

    assign byte_ready_o = (state_q != ST_RUN) && (state_q != ST_ERROR);
    assign accepted     = byte_valid_i && byte_ready_o;
    assign in_frame     = is_frame_state(state_q);
    assign start_seen   = (state_q == ST_IDLE) && accepted && (byte_i == START_MARK);
    assign len_rx       = {byte_i, len_lo_q};
    assign pk_accept    = accepted && (state_q == ST_DATA);
    assign pk_clear     = accepted && (state_q == ST_LEN_HI);
    assign word_done    = pk_accept && pk_last_lane;

    // Fires on the TIMEOUT-th consecutive idle cycle; a byte accepted in that
    // same cycle wins.
    assign timeout_hit  = in_frame && !accepted && (idle_q == IDLE_W'(TIMEOUT - 1));

    boot_loader_ctrl_byte_packer u_packer (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .data        (byte_i),
        .accept      (pk_accept),
        .clear       (pk_clear),
        .word        (imem_wdata_o),
        .word_valid  (imem_we_o),
        .last_lane   (pk_last_lane)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every variable is given a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (timeout_hit) begin
            state_d = ST_ERROR;
            err_d   = ERR_TIMEOUT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_seen) state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (accepted) state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (accepted) begin
                        if ((len_rx == 16'd0) || (len_rx > MAX_LEN)) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_LEN;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done && (word_cnt_q + 16'd1 == len_q)) state_d = ST_END;
                end
                ST_END: begin
                    if (accepted) begin
                        if (byte_i == END_MARK) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = ERR_END;
                        end
                    end
                end
                ST_RUN, ST_ERROR: begin
                    if (clear_i) begin
                        state_d = ST_IDLE;
                        err_d   = ERR_NONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            idle_q      <= '0;
            imem_addr_o <= '0;
            cpu_start_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            busy_o      <= is_frame_state(state_d);
            cpu_start_o <= (state_d == ST_RUN);

            if (accepted || !in_frame) begin
                idle_q <= '0;
            end else if (idle_q != IDLE_W'(TIMEOUT)) begin
                idle_q <= idle_q + 1'b1;
            end

            if (start_seen) begin
                word_cnt_q <= 16'd0;
            end
            if ((state_q == ST_LEN_LO) && accepted) begin
                len_lo_q <= byte_i;
            end
            if (pk_clear) begin
                len_q      <= len_rx;
                word_cnt_q <= 16'd0;
            end
            // Address is captured now; the packer presents data and strobe
            // in the following cycle, together with this address.
            if (word_done) begin
                imem_addr_o <= word_cnt_q[ADDR_W-1:0];
                word_cnt_q  <= word_cnt_q + 16'd1;
            end
        end
    end

    assign err_o      = err_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// ----------------------------------------------------------------------------
// tb_boot_loader_ctrl
// Self-checking bench for boot_loader_ctrl: directed frames from the test
// plan plus randomized frames compared against a frame-level parsing model.
// ----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

    localparam int TIMEOUT = 1024;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        clear_i;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_start_o;
    logic        busy_o;
    logic [1:0]  err_o;
    logic [15:0] word_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Observed writes {addr, data} and count of strobes wider than one cycle.
    logic [39:0] got_wr_q[$];
    int          wide_pulses = 0;
    logic        we_prev = 1'b0;

    // Model expectations.
    logic [39:0] exp_wr_q[$];
    logic [1:0]  exp_err;
    logic        exp_start;
    logic [15:0] exp_cnt;

    boot_loader_ctrl #(
        .IMEM_DEPTH (256),
        .ADDR_W     (8),
        .START_MARK (8'hA5),
        .END_MARK   (8'h5A),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset_n  (sys_reset_n),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .clear_i      (clear_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_start_o  (cpu_start_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (imem_we_o) begin
            got_wr_q.push_back({imem_addr_o, imem_wdata_o});
            if (we_prev) wide_pulses <= wide_pulses + 1;
        end
        we_prev <= imem_we_o;
    end

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int min_gap, input int max_gap);
        foreach (s[k]) begin
            repeat ($urandom_range(min_gap, max_gap)) tick();
            byte_i       = s[k];
            byte_valid_i = 1'b1;
            tick();
            byte_valid_i = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic reset_pulse();
        sys_reset_n = 1'b0;
        tick();
        sys_reset_n = 1'b1;
    endtask

    // Frame-level reference: skip bytes until the start mark, read the count,
    // then assemble each group of four payload bytes into one word.
    function automatic void model_frame(input logic [7:0] s[$]);
        int          i;
        logic [15:0] len;
        logic [31:0] w;
        exp_wr_q.delete();
        exp_err   = 2'd0;
        exp_start = 1'b0;
        exp_cnt   = 16'd0;
        i = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        i++;
        len = {s[i+1], s[i]};
        i += 2;
        if (len == 16'd0 || len > 16'd256) begin
            exp_err = 2'd1;
            return;
        end
        for (int n = 0; n < int'(len); n++) begin
            w = 32'(s[i]) + (32'(s[i+1]) << 8) + (32'(s[i+2]) << 16) + (32'(s[i+3]) << 24);
            exp_wr_q.push_back({8'(n), w});
            i += 4;
        end
        exp_cnt = len;
        if (s[i] == 8'h5A) exp_start = 1'b1;
        else               exp_err   = 2'd2;
    endfunction

    task automatic test_reset();
        sys_reset_n  = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        clear_i      = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o, cpu_start_o, busy_o, err_o, word_cnt_o, byte_ready_o}
            !== {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_values: got we=%0b addr=%h data=%h start=%0b busy=%0b err=%0d cnt=%0d ready=%0b expected 0,0,0,0,0,0,0,1",
                     imem_we_o, imem_addr_o, imem_wdata_o, cpu_start_o, busy_o, err_o, word_cnt_o, byte_ready_o);
        end
        sys_reset_n = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || byte_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%0b ready=%0b expected 0 1", busy_o, byte_ready_o);
        end
    endtask

    // Test plan frame; gap = idle cycles before each byte.
    task automatic test_good_frame(input int gap, input string tag);
        logic [7:0] s[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00};
        got_wr_q.delete();
        wide_pulses = 0;
        send_stream(s, gap, gap);
        repeat (gap) tick();
        byte_i       = 8'h5A;
        byte_valid_i = 1'b1;
        n_checks++;
        if (cpu_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s start_early: got %0b expected 0", tag, cpu_start_o);
        end
        tick();
        byte_valid_i = 1'b0;
        n_checks++;
        if (cpu_start_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s start_after_end: got %0b expected 1", tag, cpu_start_o);
        end
        tick();
        n_checks++;
        if (got_wr_q.size() != 2 || got_wr_q[0] !== {8'h00, 32'h00100513}
            || got_wr_q[1] !== {8'h01, 32'h00200593}) begin
            n_errors++;
            $display("FAIL %s writes: got %0d writes expected 2 (0:00100513, 1:00200593)", tag, got_wr_q.size());
        end
        n_checks++;
        if (word_cnt_o !== 16'd2 || err_o !== 2'd0 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s status: got cnt=%0d err=%0d busy=%0b ready=%0b expected 2 0 0 0",
                     tag, word_cnt_o, err_o, busy_o, byte_ready_o);
        end
        n_checks++;
        if (wide_pulses !== 0) begin
            n_errors++;
            $display("FAIL %s we_width: got %0d wide pulses expected 0", tag, wide_pulses);
        end
        pulse_clear();
        n_checks++;
        if (cpu_start_o !== 1'b0 || word_cnt_o !== 16'd2 || byte_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s clear_run: got start=%0b cnt=%0d ready=%0b expected 0 2 1",
                     tag, cpu_start_o, word_cnt_o, byte_ready_o);
        end
    endtask

    task automatic test_len_err();
        logic [7:0] z[$] = '{8'hA5, 8'h00, 8'h00};
        logic [7:0] big[$] = '{8'hA5, 8'h01, 8'h01};
        got_wr_q.delete();
        send_stream(z, 0, 0);
        tick();
        n_checks++;
        if (err_o !== 2'd1 || byte_ready_o !== 1'b0 || got_wr_q.size() != 0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL len_zero: got err=%0d ready=%0b writes=%0d busy=%0b expected 1 0 0 0",
                     err_o, byte_ready_o, got_wr_q.size(), busy_o);
        end
        pulse_clear();
        n_checks++;
        if (err_o !== 2'd0 || byte_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL len_zero_clear: got err=%0d ready=%0b expected 0 1", err_o, byte_ready_o);
        end
        send_stream(big, 0, 0);
        n_checks++;
        if (err_o !== 2'd1) begin
            n_errors++;
            $display("FAIL len_257: got err=%0d expected 1", err_o);
        end
        pulse_clear();
        n_checks++;
        if (err_o !== 2'd0) begin
            n_errors++;
            $display("FAIL len_257_clear: got err=%0d expected 0", err_o);
        end
    endtask

    task automatic test_end_err();
        logic [7:0] s[$] = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
        got_wr_q.delete();
        send_stream(s, 0, 0);
        tick();
        n_checks++;
        if (got_wr_q.size() != 1 || got_wr_q[0] !== {8'h00, 32'h44332211}) begin
            n_errors++;
            $display("FAIL end_err_write: got %0d writes expected 1 (0:44332211)", got_wr_q.size());
        end
        n_checks++;
        if (err_o !== 2'd2 || cpu_start_o !== 1'b0 || word_cnt_o !== 16'd1) begin
            n_errors++;
            $display("FAIL end_err_status: got err=%0d start=%0b cnt=%0d expected 2 0 1",
                     err_o, cpu_start_o, word_cnt_o);
        end
        pulse_clear();
    endtask

    task automatic test_timeout();
        logic [7:0] s[$]  = '{8'hA5, 8'h01, 8'h00, 8'h11};
        logic [7:0] a5[$] = '{8'hA5};
        got_wr_q.delete();
        send_stream(s, 0, 0);
        repeat (TIMEOUT - 1) tick();
        n_checks++;
        if (err_o !== 2'd0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_early: got err=%0d busy=%0b expected 0 1", err_o, busy_o);
        end
        tick();
        n_checks++;
        if (err_o !== 2'd3 || busy_o !== 1'b0 || got_wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL timeout_fire: got err=%0d busy=%0b writes=%0d expected 3 0 0",
                     err_o, busy_o, got_wr_q.size());
        end
        pulse_clear();
        // A byte on the TIMEOUT-th idle cycle beats the timeout.
        send_stream(a5, 0, 0);
        repeat (TIMEOUT - 1) tick();
        byte_i       = 8'h01;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
        n_checks++;
        if (err_o !== 2'd0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_byte_wins: got err=%0d busy=%0b expected 0 1", err_o, busy_o);
        end
        reset_pulse();
    endtask

    task automatic test_reset_mid();
        logic [7:0] part[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hAA};
        logic [7:0] good[$] = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5A};
        send_stream(part, 0, 0);
        n_checks++;
        if (imem_wdata_o !== 32'h00100513 || word_cnt_o !== 16'd1 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_before_reset: got data=%h cnt=%0d busy=%0b expected 00100513 1 1",
                     imem_wdata_o, word_cnt_o, busy_o);
        end
        sys_reset_n = 1'b0;
        tick();
        n_checks++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o, cpu_start_o, busy_o, err_o, word_cnt_o, byte_ready_o}
            !== {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_reset_values: got data=%h busy=%0b cnt=%0d ready=%0b expected 0 0 0 1",
                     imem_wdata_o, busy_o, word_cnt_o, byte_ready_o);
        end
        sys_reset_n = 1'b1;
        got_wr_q.delete();
        send_stream(good, 0, 0);
        tick();
        n_checks++;
        if (cpu_start_o !== 1'b1 || got_wr_q.size() != 1 || got_wr_q[0] !== {8'h00, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL fresh_frame: got start=%0b writes=%0d expected 1 1 (0:deadbeef)",
                     cpu_start_o, got_wr_q.size());
        end
        reset_pulse();
        n_checks++;
        if (cpu_start_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_run: got start=%0b expected 0", cpu_start_o);
        end
    endtask

    task automatic test_random(input int frames);
        logic [7:0] s[$];
        int         len, kind;
        logic [7:0] b;
        for (int f = 0; f < frames; f++) begin
            s.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
            kind = $urandom_range(0, 4);
            if (kind == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(257, 2000);
            else           len = $urandom_range(1, 8);
            s.push_back(8'hA5);
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            if (kind != 0) begin
                repeat (4 * len) s.push_back(8'($urandom_range(0, 255)));
                if (kind == 1) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h5A) b = 8'h5B;
                    s.push_back(b);
                end else begin
                    s.push_back(8'h5A);
                end
            end
            model_frame(s);
            got_wr_q.delete();
            wide_pulses = 0;
            send_stream(s, 0, 3);
            tick();
            tick();
            n_checks++;
            if (got_wr_q.size() != exp_wr_q.size()) begin
                n_errors++;
                $display("FAIL rand%0d write_count: got %0d expected %0d", f, got_wr_q.size(), exp_wr_q.size());
            end else begin
                foreach (exp_wr_q[k]) begin
                    n_checks++;
                    if (got_wr_q[k] !== exp_wr_q[k]) begin
                        n_errors++;
                        $display("FAIL rand%0d write%0d: got %h expected %h", f, k, got_wr_q[k], exp_wr_q[k]);
                    end
                end
            end
            n_checks++;
            if (err_o !== exp_err || cpu_start_o !== exp_start || word_cnt_o !== exp_cnt || wide_pulses !== 0) begin
                n_errors++;
                $display("FAIL rand%0d status: got err=%0d start=%0b cnt=%0d wide=%0d expected %0d %0b %0d 0",
                         f, err_o, cpu_start_o, word_cnt_o, wide_pulses, exp_err, exp_start, exp_cnt);
            end
            pulse_clear();
            n_checks++;
            if (err_o !== 2'd0 || cpu_start_o !== 1'b0 || byte_ready_o !== 1'b1 || word_cnt_o !== exp_cnt) begin
                n_errors++;
                $display("FAIL rand%0d clear: got err=%0d start=%0b ready=%0b cnt=%0d expected 0 0 1 %0d",
                         f, err_o, cpu_start_o, byte_ready_o, word_cnt_o, exp_cnt);
            end
        end
    endtask

    initial begin
        sys_reset_n  = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        clear_i      = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_good_frame(0, "back_to_back");
        test_good_frame(1, "toggle_valid");
        test_len_err();
        test_end_err();
        test_timeout();
        test_reset_mid();
        test_random(30);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
